// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, constants and key-code lookup for the keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        PRESSED   = 2'd2,
        DEB_REL   = 2'd3
    } kp_state_t;

    localparam logic [3:0] KEY_NONE = 4'hF;

    typedef struct packed {
        logic       valid;
        logic [3:0] code;
    } key_t;

    // Row-major 4x4 layout; '#' is reported as invalid so the scanner skips it.
    function automatic key_t key_code(input logic [1:0] row_idx, input logic [1:0] col_idx);
        key_t k;
        k.valid = 1'b1;
        k.code  = KEY_NONE;
        case ({row_idx, col_idx})
            4'h0: k.code = 4'h1;
            4'h1: k.code = 4'h2;
            4'h2: k.code = 4'h3;
            4'h3: k.code = 4'hA;
            4'h4: k.code = 4'h4;
            4'h5: k.code = 4'h5;
            4'h6: k.code = 4'h6;
            4'h7: k.code = 4'hB;
            4'h8: k.code = 4'h7;
            4'h9: k.code = 4'h8;
            4'hA: k.code = 4'h9;
            4'hB: k.code = 4'hC;
            4'hC: k.code = 4'hE;
            4'hD: k.code = 4'h0;
            4'hE: k.valid = 1'b0;
            4'hF: k.code = 4'hD;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer, asynchronous reset to all ones.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with press/release debounce.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYC = 27000,
    parameter int DEB_CYC  = 540000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] sample,
    output logic       key_stb
);

    localparam int CNT_MAX = (SCAN_CYC > DEB_CYC) ? SCAN_CYC : DEB_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYC - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);

    logic [3:0]       row_s;
    kp_state_t        state, state_n;
    logic [1:0]       ci, ci_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       lat_row, lat_row_n;
    logic [3:0]       lat_code, lat_code_n;
    logic [3:0]       sample_n;
    logic             key_stb_n;
    logic             one_low;
    logic [1:0]       row_idx;
    key_t             hit;

    sync2 #(.WIDTH(4)) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row),
        .q     (row_s)
    );

    // Column drive follows ci directly so reset forces 4'b1110 without a clock.
    assign col = ~(4'b0001 << ci);

    always_comb begin
        one_low = 1'b0;
        row_idx = 2'd0;
        case (row_s)
            4'b1110: begin one_low = 1'b1; row_idx = 2'd0; end
            4'b1101: begin one_low = 1'b1; row_idx = 2'd1; end
            4'b1011: begin one_low = 1'b1; row_idx = 2'd2; end
            4'b0111: begin one_low = 1'b1; row_idx = 2'd3; end
            default: ;
        endcase
    end

    assign hit = key_code(row_idx, ci);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SCAN;
            ci       <= 2'd0;
            cnt      <= '0;
            lat_row  <= 4'hF;
            lat_code <= KEY_NONE;
            sample   <= KEY_NONE;
            key_stb  <= 1'b0;
        end else begin
            state    <= state_n;
            ci       <= ci_n;
            cnt      <= cnt_n;
            lat_row  <= lat_row_n;
            lat_code <= lat_code_n;
            sample   <= sample_n;
            key_stb  <= key_stb_n;
        end
    end

    always_comb begin
        state_n    = state;
        ci_n       = ci;
        cnt_n      = cnt;
        lat_row_n  = lat_row;
        lat_code_n = lat_code;
        sample_n   = sample;
        key_stb_n  = 1'b0;
        case (state)
            SCAN: begin
                if (cnt == SCAN_LAST) begin
                    cnt_n = '0;
                    if (one_low && hit.valid) begin
                        lat_row_n  = row_s;
                        lat_code_n = hit.code;
                        state_n    = DEB_PRESS;
                    end else begin
                        ci_n = ci + 2'd1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DEB_PRESS: begin
                if (row_s != lat_row) begin
                    cnt_n   = '0;
                    ci_n    = ci + 2'd1;
                    state_n = SCAN;
                end else if (cnt == DEB_LAST) begin
                    cnt_n     = '0;
                    sample_n  = lat_code;
                    key_stb_n = 1'b1;
                    state_n   = PRESSED;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PRESSED: begin
                // Other rows in this column going low are deliberately ignored.
                if (row_s == 4'hF) begin
                    cnt_n   = '0;
                    state_n = DEB_REL;
                end
            end
            DEB_REL: begin
                if (row_s != 4'hF) begin
                    cnt_n   = '0;
                    state_n = PRESSED;
                end else if (cnt == DEB_LAST) begin
                    cnt_n    = '0;
                    sample_n = KEY_NONE;
                    ci_n     = ci + 2'd1;
                    state_n  = SCAN;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = SCAN;
        endcase
    end

endmodule
